// File: rtl/qea_core.sv
// qea_core: state-vector quantum circuit emulator applying 2x2 complex gates in place.
// Optional build macro QEA_SATURATE_EN: saturating re/im sums instead of wrapping.
//  state   | meaning
//  S_IDLE  | host owns state/ctx RAMs, waits for i_start
//  S_FETCH | decode one ctx header word
//  S_MAT   | load U00..U11 from the next four ctx words
//  S_PAIR  | read/multiply/add/write per amplitude pair
//  S_DONE  | raise o_complete, return to idle
module qea_core #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);
  localparam int AW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = STATE_DATA_WIDTH;
  localparam int CW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int GW = GATE_ADDR_WIDTH;
  localparam logic [3:0] OP_END = 4'd0;
  localparam logic [3:0] OP_U   = 4'd1;
  localparam logic [3:0] OP_CU  = 4'd2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAT, S_PAIR, S_DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]                      amp [2**AW];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx [2**CW];

  logic [CW-1:0]              pc;
  logic [MAX_QBIT_WIDTH-1:0]  qbit_n;
  logic                       is_cu, gate_skip;
  logic [GW-1:0]              ctl, tgt;
  logic [1:0]                 mat_idx, phase;
  logic [AW-1:0]              j;
  logic [GATE_DATA_WIDTH-1:0] u [4];
  logic [SW-1:0]              a [2];
  logic [SW-1:0]              res [2];
  logic [ALU_DATA_WIDTH-1:0]  prod [2][2][4];

  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_rd;
  logic [3:0]                         hdr_op;
  logic [GW-1:0]                      hdr_ctl, hdr_tgt;
  logic                               hdr_skip;
  logic [AW-1:0]                      tgt_bit, lo_mask, i0, i1, j_last;
  logic                               pair_skip, pair_last, host_act;
  logic [PE_NUM*SW-1:0]               row_rd;

  function automatic logic [ALU_DATA_WIDTH-1:0] fmul(input logic [DW-1:0] x,
                                                     input logic [DW-1:0] y);
    logic signed [2*DW-1:0] p;
    p = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
    return ALU_DATA_WIDTH'(p >>> NUM_FRAC_BIT);
  endfunction

  function automatic logic [DW-1:0] sadd(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] s;
`ifdef QEA_SATURATE_EN
    s = x + y;
    if (x[DW-1] == y[DW-1] && s[DW-1] != x[DW-1])
      s = x[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    s = x + y;
`endif
    return s;
  endfunction

  function automatic logic [DW-1:0] ssub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] s;
`ifdef QEA_SATURATE_EN
    s = x - y;
    if (x[DW-1] != y[DW-1] && s[DW-1] != x[DW-1])
      s = x[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    s = x - y;
`endif
    return s;
  endfunction

  assign ctx_rd   = ctx[pc];
  assign hdr_op   = ctx_rd[GATE_CONTEXT_DATA_WIDTH-1 -: 4];
  assign hdr_ctl  = ctx_rd[8 +: GW];
  assign hdr_tgt  = ctx_rd[0 +: GW];
  assign hdr_skip = (int'(hdr_tgt) >= int'(qbit_n)) ||
                    (hdr_op == OP_CU && (int'(hdr_ctl) >= int'(qbit_n) || hdr_ctl == hdr_tgt));

  // i0 is j with a zero spliced in at the target bit position
  assign tgt_bit   = AW'(1) << tgt;
  assign lo_mask   = tgt_bit - AW'(1);
  assign i0        = ((j & ~lo_mask) << 1) | (j & lo_mask);
  assign i1        = i0 | tgt_bit;
  assign j_last    = (AW'(1) << (qbit_n - MAX_QBIT_WIDTH'(1))) - AW'(1);
  assign pair_skip = is_cu && !(|(i0 & (AW'(1) << ctl)));
  assign pair_last = (j == j_last);
  assign host_act  = (state == S_IDLE) && i_state_ena;

  always_comb begin
    row_rd = '0;
    for (int p = 0; p < PE_NUM; p++)
      row_rd[(PE_NUM-p)*SW-1 -: SW] = amp[{i_state_addra, PE_NUM_WIDTH'(p)}];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (pc == '1 || hdr_op == OP_END) state_nxt = S_DONE;
        else if (hdr_op == OP_U || hdr_op == OP_CU) state_nxt = S_MAT;
      end
      S_MAT: begin
        if (pc == '1) state_nxt = S_DONE;
        else if (mat_idx == 2'd3) state_nxt = gate_skip ? S_FETCH : S_PAIR;
      end
      S_PAIR: begin
        if (pair_last && ((phase == 2'd0 && pair_skip) || phase == 2'd3))
          state_nxt = S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= S_IDLE;
      o_complete   <= 1'b0;
      o_state_dout <= '0;
      pc           <= '0;
      qbit_n       <= '0;
      is_cu        <= 1'b0;
      gate_skip    <= 1'b0;
      ctl          <= '0;
      tgt          <= '0;
      mat_idx      <= '0;
      phase        <= '0;
      j            <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (i_state_ena) o_state_dout <= row_rd;
          if (i_start) begin
            o_complete <= 1'b0;
            pc         <= '0;
            qbit_n     <= i_qbit_num;
          end
        end
        S_FETCH: begin
          pc        <= pc + CW'(1);
          is_cu     <= (hdr_op == OP_CU);
          gate_skip <= hdr_skip;
          ctl       <= hdr_ctl;
          tgt       <= hdr_tgt;
          mat_idx   <= '0;
        end
        S_MAT: begin
          pc      <= pc + CW'(1);
          mat_idx <= mat_idx + 2'd1;
          j       <= '0;
          phase   <= '0;
        end
        S_PAIR: begin
          if (phase == 2'd0 && pair_skip) begin
            j <= j + AW'(1);
          end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) j <= j + AW'(1);
          end
        end
        S_DONE:  o_complete <= 1'b1;
        default: ;
      endcase
    end
  end

  // RAMs and pipeline registers keep their contents through reset; only writes are gated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (state == S_IDLE && i_ctx_en && i_ctx_wea) ctx[i_ctx_addr] <= i_ctx_data;
      if (host_act && i_state_wea)
        for (int p = 0; p < PE_NUM; p++)
          amp[{i_state_addra, PE_NUM_WIDTH'(p)}] <= i_state_dina[(PE_NUM-p)*SW-1 -: SW];
      if (state == S_MAT) u[mat_idx] <= ctx_rd;
      if (state == S_PAIR) begin
        case (phase)
          2'd0: begin
            a[0] <= amp[i0];
            a[1] <= amp[i1];
          end
          2'd1: begin
            for (int r = 0; r < 2; r++)
              for (int k = 0; k < 2; k++) begin
                prod[r][k][0] <= fmul(u[2*r+k][SW-1 -: DW], a[k][SW-1 -: DW]);
                prod[r][k][1] <= fmul(u[2*r+k][DW-1:0],     a[k][DW-1:0]);
                prod[r][k][2] <= fmul(u[2*r+k][SW-1 -: DW], a[k][DW-1:0]);
                prod[r][k][3] <= fmul(u[2*r+k][DW-1:0],     a[k][SW-1 -: DW]);
              end
          end
          2'd2: begin
            for (int r = 0; r < 2; r++)
              res[r] <= {sadd(ssub(prod[r][0][0], prod[r][0][1]), ssub(prod[r][1][0], prod[r][1][1])),
                         sadd(sadd(prod[r][0][2], prod[r][0][3]), sadd(prod[r][1][2], prod[r][1][3]))};
          end
          default: begin
            amp[i0] <= res[0];
            amp[i1] <= res[1];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qea_core.sv
// tb_qea_core: directed scoreboard bench for qea_core; expectations queued by the driver,
// compared by a monitor when read data, completion or level checks come due.
module tb_qea_core;
  localparam int RW = 256;
  localparam logic [63:0] ONE  = 64'h40000000_00000000;
  localparam logic [63:0] H    = 64'h2D413CCD_00000000;
  localparam logic [63:0] HN   = 64'hD2BEC333_00000000;
  localparam logic [63:0] IMG  = 64'h00000000_40000000;

  logic          clk = 1'b0;
  logic          rst_n, i_start, i_ctx_en, i_ctx_wea, i_state_ena, i_state_wea;
  logic [5:0]    i_qbit_num;
  logic [15:0]   i_ctx_addr, i_state_addra;
  logic [63:0]   i_ctx_data;
  logic [RW-1:0] i_state_dina;
  logic          o_complete;
  logic [RW-1:0] o_state_dout;

  always #5 clk = ~clk;

  qea_core dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  typedef struct { string name; logic [RW-1:0] data; } rd_exp_t;
  typedef struct { string name; bit is_cpl; logic [RW-1:0] data; } lvl_exp_t;
  typedef struct { string name; int cycles; } lat_exp_t;
  rd_exp_t  rd_q[$];
  lvl_exp_t lvl_q[$];
  lat_exp_t lat_q[$];

  int   checks = 0;
  int   errors = 0;
  logic rd_seen = 1'b0, start_seen = 1'b0, rst_seen = 1'b0;
  int   run_cnt = 0;
  bit   armed = 1'b0;

  always @(posedge clk) begin
    rd_seen    <= i_state_ena && !i_state_wea;
    start_seen <= i_start;
    rst_seen   <= rst_n;
  end

  always @(negedge clk) begin
    rd_exp_t       re;
    lvl_exp_t      le;
    lat_exp_t      te;
    logic [RW-1:0] act;
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_extra: read data %h with nothing expected", o_state_dout);
      end else begin
        re = rd_q.pop_front();
        checks++;
        if (o_state_dout !== re.data) begin
          errors++;
          $display("FAIL %s: got %h expected %h", re.name, o_state_dout, re.data);
        end
      end
    end
    while (lvl_q.size() != 0) begin
      le  = lvl_q.pop_front();
      act = le.is_cpl ? {{(RW-1){1'b0}}, o_complete} : o_state_dout;
      checks++;
      if (act !== le.data) begin
        errors++;
        $display("FAIL %s: got %h expected %h", le.name, act, le.data);
      end
    end
    if (rst_seen) armed = 1'b0;
    else if (start_seen) begin
      armed   = 1'b1;
      run_cnt = 0;
    end else if (armed) run_cnt++;
    if (armed && o_complete) begin
      armed = 1'b0;
      if (lat_q.size() == 0) begin
        errors++;
        $display("FAIL cpl_extra: o_complete rose after %0d cycles, none expected", run_cnt);
      end else begin
        te = lat_q.pop_front();
        checks++;
        if (run_cnt != te.cycles) begin
          errors++;
          $display("FAIL %s: completion after %0d cycles expected %0d", te.name, run_cnt, te.cycles);
        end
      end
    end else if (armed && run_cnt > 4000) begin
      armed = 1'b0;
      errors++;
      $display("FAIL run_timeout: o_complete never rose");
      if (lat_q.size() != 0) te = lat_q.pop_front();
    end
  end

  logic [63:0] ia [64];
  logic [63:0] ea [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [3:0] op, input int c, input int t);
    return {op, 46'd0, 6'(c), 2'd0, 6'(t)};
  endfunction

  task automatic wr_ctx(input int adr, input logic [63:0] d);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(adr); i_ctx_data = d;
    tick();
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic wr_gate(input int adr, input logic [63:0] h,
                         input logic [63:0] m0, input logic [63:0] m1,
                         input logic [63:0] m2, input logic [63:0] m3);
    wr_ctx(adr, h); wr_ctx(adr+1, m0); wr_ctx(adr+2, m1); wr_ctx(adr+3, m2); wr_ctx(adr+4, m3);
  endtask

  task automatic zero_vecs();
    for (int i = 0; i < 64; i++) begin
      ia[i] = '0;
      ea[i] = '0;
    end
  endtask

  task automatic load_state();
    for (int r = 0; r < 16; r++) begin
      i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'(r);
      i_state_dina = {ia[4*r], ia[4*r+1], ia[4*r+2], ia[4*r+3]};
      tick();
    end
    i_state_ena = 1'b0; i_state_wea = 1'b0;
  endtask

  task automatic check_state(input string tag);
    rd_exp_t e;
    for (int r = 0; r < 16; r++) begin
      i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = 16'(r);
      e.name = $sformatf("%s_row%0d", tag, r);
      e.data = {ea[4*r], ea[4*r+1], ea[4*r+2], ea[4*r+3]};
      rd_q.push_back(e);
      tick();
    end
    i_state_ena = 1'b0;
    tick();
  endtask

  task automatic lvl(input string tag, input bit is_cpl, input logic [RW-1:0] d);
    lvl_exp_t e;
    e.name = tag; e.is_cpl = is_cpl; e.data = d;
    lvl_q.push_back(e);
  endtask

  task automatic run(input int exp_lat, input string tag, input bit chk_clear);
    lat_exp_t e;
    e.name = tag; e.cycles = exp_lat;
    lat_q.push_back(e);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    if (chk_clear) lvl({tag, "_clear"}, 1'b1, '0);
    for (int k = 0; k < 6000; k++) begin
      if (lat_q.size() == 0) break;
      tick();
    end
    if (lat_q.size() != 0) begin
      $display("FAIL %s: run still pending after cycle budget", tag);
      $fatal(1, "bench stuck");
    end
    lvl({tag, "_cpl"}, 1'b1, {{(RW-1){1'b0}}, 1'b1});
    tick();
  endtask

  initial begin
    rst_n = 1'b1; i_start = 1'b0; i_qbit_num = 6'd6;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
    i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
    repeat (3) tick();
    lvl("rst_cpl", 1'b1, '0);
    lvl("rst_dout", 1'b0, '0);
    tick();
    rst_n = 1'b0;
    tick();

    // X on qubit 0 from |0>
    zero_vecs(); ia[0] = ONE; ea[1] = ONE;
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), 64'd0, ONE, ONE, 64'd0);
    wr_ctx(5, hdr(4'd0, 0, 0));
    run(135, "x", 1'b0);
    check_state("x");

    // Hadamard on qubit 0
    zero_vecs(); ia[0] = ONE; ea[0] = H; ea[1] = H;
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), H, H, H, HN);
    wr_ctx(5, hdr(4'd0, 0, 0));
    run(135, "h", 1'b0);
    check_state("h");

    // X t=0 then CX c=0 t=5: half the CU pairs skip in one cycle
    zero_vecs(); ia[0] = ONE; ea[33] = ONE;
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), 64'd0, ONE, ONE, 64'd0);
    wr_gate(5, hdr(4'd2, 0, 5), 64'd0, ONE, ONE, 64'd0);
    wr_ctx(10, hdr(4'd0, 0, 0));
    run(220, "cx", 1'b0);
    check_state("cx");

    // whole-gate skips (t>=n, c==t, c>=n) and a NOP leave the state untouched
    zero_vecs();
    for (int i = 0; i < 64; i++) begin
      ia[i] = {32'(i*3+1), 32'(i+7)};
      ea[i] = ia[i];
    end
    load_state();
    wr_gate(0,  hdr(4'd1, 0, 6), 64'd0, ONE, ONE, 64'd0);
    wr_gate(5,  hdr(4'd2, 3, 3), 64'd0, ONE, ONE, 64'd0);
    wr_gate(10, hdr(4'd2, 6, 1), 64'd0, ONE, ONE, 64'd0);
    wr_ctx(15, hdr(4'd7, 0, 0));
    wr_ctx(16, hdr(4'd0, 0, 0));
    run(18, "skip", 1'b0);
    check_state("skip");

    // sum overflow: 0x7FFFFFFF + 0x7FFFFFFF
    zero_vecs(); ia[0] = ONE; ia[1] = ONE;
`ifdef QEA_SATURATE_EN
    ea[0] = 64'h7FFFFFFF_00000000;
`else
    ea[0] = 64'hFFFFFFFE_00000000;
`endif
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), 64'h7FFFFFFF_00000000, 64'h7FFFFFFF_00000000, 64'd0, 64'd0);
    wr_ctx(5, hdr(4'd0, 0, 0));
    run(135, "ovf", 1'b0);
    check_state("ovf");

    // phase gate diag(1, i) exercises imaginary and negative products
    zero_vecs();
    ia[0]  = 64'h20000000_E0000000; ea[0]  = 64'h20000000_E0000000;
    ia[1]  = 64'h20000000_10000000; ea[1]  = 64'hF0000000_20000000;
    ia[2]  = ONE;                   ea[2]  = ONE;
    ia[11] = 64'hC0000000_00000000; ea[11] = 64'h00000000_C0000000;
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), ONE, 64'd0, 64'd0, IMG);
    wr_ctx(5, hdr(4'd0, 0, 0));
    run(135, "phase", 1'b0);
    check_state("phase");

    // reset mid-run: outputs cleared, host reads work immediately, pair 0 already written
    zero_vecs(); ia[0] = ONE;
    load_state();
    wr_gate(0, hdr(4'd1, 0, 0), 64'd0, ONE, ONE, 64'd0);
    wr_ctx(5, hdr(4'd0, 0, 0));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (40) tick();
    rst_n = 1'b1;
    tick();
    lvl("midrst_cpl", 1'b1, '0);
    lvl("midrst_dout", 1'b0, '0);
    rst_n = 1'b0;
    begin
      rd_exp_t e;
      i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = 16'd0;
      e.name = "midrst_row0"; e.data = {64'd0, ONE, 64'd0, 64'd0};
      rd_q.push_back(e);
      tick();
      i_state_ena = 1'b0;
      tick();
    end

    // END-only program, then a restart that must clear o_complete
    zero_vecs();
    for (int i = 0; i < 64; i++) begin
      ia[i] = {32'(64 - i), 32'(i*5)};
      ea[i] = ia[i];
    end
    load_state();
    wr_ctx(0, hdr(4'd0, 0, 0));
    run(2, "end", 1'b0);
    check_state("end");
    run(2, "restart", 1'b1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
